// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : State encoding and exception cause codes for the mul/div sequencer.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        WRITE    = 3'd3,
        EXC      = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_DIV0    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/muldiv_timer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_timer
// Brief    : Run-cycle counter; flags expiry once TIMEOUT cycles have elapsed.
// Revision : 1.0
// ============================================================================
module muldiv_timer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Starts the mult/div unit, waits for completion and commits HI/LO,
//            trapping divide-by-zero and unit hang as exceptions.
// Revision : 1.0
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] divisor,
    input  logic        mult_end,
    input  logic        div_end,
    input  logic        div_zero,
    output logic        MultCtrl,
    output logic        DivCtrl,
    output logic        HILOCtrl,
    output logic        WriteHILO,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic [1:0]  exc_cause
);

    state_t     r_state;
    state_t     w_stateNext;
    logic       w_timerExpired;
    logic       r_multCtrl, r_divCtrl, r_hiloCtrl, r_write, r_busy, r_done, r_exc;
    logic [1:0] r_excCause;
    logic       w_multCtrlNext, w_divCtrlNext, w_hiloNext, w_writeNext, w_doneNext, w_excNext;
    logic [1:0] w_causeNext;

    muldiv_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == IDLE),
        .i_enable  ((r_state == MULT_RUN) || (r_state == DIV_RUN)),
        .o_expired (w_timerExpired)
    );

    always_comb begin
        w_stateNext    = r_state;
        w_multCtrlNext = 1'b0;
        w_divCtrlNext  = 1'b0;
        w_hiloNext     = r_hiloCtrl;
        w_writeNext    = 1'b0;
        w_doneNext     = 1'b0;
        w_excNext      = 1'b0;
        w_causeNext    = r_excCause;
        case (r_state)
            IDLE: begin
                // Multiply wins when both starts arrive together.
                if (start_mult) begin
                    w_stateNext    = MULT_RUN;
                    w_multCtrlNext = 1'b1;
                    w_hiloNext     = 1'b0;
                end else if (start_div) begin
                    if (divisor != 32'd0) begin
                        w_stateNext   = DIV_RUN;
                        w_divCtrlNext = 1'b1;
                        w_hiloNext    = 1'b1;
                    end else begin
                        w_stateNext = EXC;
                        w_excNext   = 1'b1;
                        w_causeNext = CAUSE_DIV0;
                    end
                end
            end
            MULT_RUN: begin
                if (mult_end) begin
                    w_stateNext = WRITE;
                    w_writeNext = 1'b1;
                    w_doneNext  = 1'b1;
                end else if (w_timerExpired) begin
                    w_stateNext = EXC;
                    w_excNext   = 1'b1;
                    w_causeNext = CAUSE_TIMEOUT;
                end
            end
            DIV_RUN: begin
                if (div_zero) begin
                    w_stateNext = EXC;
                    w_excNext   = 1'b1;
                    w_causeNext = CAUSE_DIV0;
                end else if (div_end) begin
                    w_stateNext = WRITE;
                    w_writeNext = 1'b1;
                    w_doneNext  = 1'b1;
                end else if (w_timerExpired) begin
                    w_stateNext = EXC;
                    w_excNext   = 1'b1;
                    w_causeNext = CAUSE_TIMEOUT;
                end
            end
            WRITE:   w_stateNext = IDLE;
            EXC:     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Every output is registered from its next-state value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_multCtrl <= 1'b0;
            r_divCtrl  <= 1'b0;
            r_hiloCtrl <= 1'b0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_exc      <= 1'b0;
            r_excCause <= CAUSE_NONE;
        end else begin
            r_state    <= w_stateNext;
            r_multCtrl <= w_multCtrlNext;
            r_divCtrl  <= w_divCtrlNext;
            r_hiloCtrl <= w_hiloNext;
            r_write    <= w_writeNext;
            r_busy     <= (w_stateNext != IDLE);
            r_done     <= w_doneNext;
            r_exc      <= w_excNext;
            r_excCause <= w_causeNext;
        end
    end

    assign MultCtrl  = r_multCtrl;
    assign DivCtrl   = r_divCtrl;
    assign HILOCtrl  = r_hiloCtrl;
    assign WriteHILO = r_write;
    assign busy      = r_busy;
    assign done      = r_done;
    assign exc       = r_exc;
    assign exc_cause = r_excCause;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Directed per-cycle checks of the mul/div sequencer outputs.
// Revision : 1.0
// ============================================================================
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] divisor;
    logic        mult_end, div_end, div_zero;
    logic        MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, exc;
    logic [1:0]  exc_cause;

    int         errCount = 0;
    int         chkCount = 0;
    logic       heldHilo;
    logic [1:0] heldCause;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .divisor    (divisor),
        .mult_end   (mult_end),
        .div_end    (div_end),
        .div_zero   (div_zero),
        .MultCtrl   (MultCtrl),
        .DivCtrl    (DivCtrl),
        .HILOCtrl   (HILOCtrl),
        .WriteHILO  (WriteHILO),
        .busy       (busy),
        .done       (done),
        .exc        (exc),
        .exc_cause  (exc_cause)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit order: MultCtrl DivCtrl HILOCtrl WriteHILO busy done exc exc_cause[1:0]
    function automatic logic [8:0] outVec();
        return {MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, exc, exc_cause};
    endfunction

    // Cycle 0 carries the start; -1 means "never" for any cycle argument.
    task automatic runOp(input string name, input int op, input logic [31:0] dvs,
                         input int endC, input int zeroC, input int rstC, input int busyC,
                         input bit both, input int nCyc, input int ctrlC, input int writeC,
                         input int excC, input logic [1:0] cause, input logic hilo);
        int lastBusy;
        lastBusy = (writeC >= 0) ? writeC : excC;
        if (rstC >= 0) lastBusy = rstC;
        for (int c = 0; c < nCyc; c++) begin
            logic [8:0] e;
            e[8]   = (op == 0) && (c == ctrlC);
            e[7]   = (op == 1) && (c == ctrlC);
            e[6]   = (c == 0) ? heldHilo : hilo;
            e[5]   = (c == writeC);
            e[4]   = (c >= 1) && (c <= lastBusy);
            e[3]   = (c == writeC);
            e[2]   = (c == excC);
            e[1:0] = (excC >= 0 && c >= excC) ? cause : heldCause;
            if (rstC >= 0 && c > rstC) e = '0;
            checkVal($sformatf("%s c%0d", name, c), {23'd0, outVec()}, {23'd0, e});
            reset      = (c == rstC);
            start_mult = (c == 0) && (op == 0 || both);
            start_div  = ((c == 0) && (op == 1 || both)) || (c == busyC);
            divisor    = (c == busyC) ? 32'd3 : dvs;
            mult_end   = (op == 0) && (c == endC);
            div_end    = (op == 1) && (c == endC);
            div_zero   = (c == zeroC);
            @(posedge clk);
            #1;
        end
        {reset, start_mult, start_div, mult_end, div_end, div_zero} = '0;
        divisor = '0;
        if (rstC >= 0) begin
            heldHilo  = 1'b0;
            heldCause = 2'b00;
        end else begin
            heldHilo = hilo;
            if (excC >= 0) heldCause = cause;
        end
    endtask

    initial begin
        reset = 1'b1;
        {start_mult, start_div, mult_end, div_end, div_zero} = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset", {23'd0, outVec()}, 32'd0);
        reset     = 1'b0;
        heldHilo  = 1'b0;
        heldCause = 2'b00;

        //    name        op dvs   end zero rst busy both n  ctrl wr  exc cause  hilo
        runOp("mul",       0, 0,    33, -1, -1, -1, 0, 36, 1, 34, -1, 2'b00, 1'b0);
        runOp("div",       1, 7,    34, -1, -1, -1, 0, 37, 1, 35, -1, 2'b00, 1'b1);
        runOp("div0pre",   1, 0,    -1, -1, -1, -1, 0,  3,-1, -1,  1, 2'b01, 1'b1);
        runOp("div0unit",  1, 5,    10, 10, -1, -1, 0, 13, 1, -1, 11, 2'b01, 1'b1);
        runOp("timeout",   0, 0,    -1, -1, -1, -1, 0, 67, 1, -1, 65, 2'b10, 1'b0);
        runOp("edge64",    0, 0,    64, -1, -1, -1, 0, 67, 1, 65, -1, 2'b00, 1'b0);
        runOp("both",      0, 4,     5, -1, -1, -1, 1,  8, 1,  6, -1, 2'b00, 1'b0);
        runOp("busyStart", 0, 0,    12, -1, -1,  5, 0, 15, 1, 13, -1, 2'b00, 1'b0);
        runOp("divFast",   1, 9,     1, -1, -1, -1, 0,  4, 1,  2, -1, 2'b00, 1'b1);
        runOp("rstMid",    0, 0,    20, -1, 10, -1, 0, 24, 1, -1, -1, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
`default_nettype wire
